// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice allocator with retrigger and oldest-voice stealing
module voice_allocator #(
  parameter int VOICE_COUNT    = 8,
  parameter int NOTE_WIDTH     = 7,
  parameter int VELOCITY_WIDTH = 7,
  parameter int AGE_WIDTH      = 8
) (
  input  logic                                  clock_50_000_000,
  input  logic                                  reset_l,
  input  logic                                  event_valid,
  output logic                                  event_ready,
  input  logic                                  event_is_on,
  input  logic [NOTE_WIDTH-1:0]                 event_note,
  input  logic [VELOCITY_WIDTH-1:0]             event_velocity,
  input  logic [VOICE_COUNT-1:0]                envelope_end,
  output logic [VOICE_COUNT-1:0]                voice_note_on,
  output logic [VOICE_COUNT-1:0]                voice_note_off,
  output logic [VOICE_COUNT*NOTE_WIDTH-1:0]     voice_note,
  output logic [VOICE_COUNT*VELOCITY_WIDTH-1:0] voice_velocity,
  output logic [VOICE_COUNT-1:0]                voice_active,
  output logic [VOICE_COUNT-1:0]                voice_held,
  output logic                                  steal
);

  localparam int IDX_WIDTH = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;

  typedef enum logic [1:0] {IDLE, SEARCH, ISSUE} ctrl_state_t;
  typedef enum logic [1:0] {V_FREE, V_HELD, V_RELEASING} voice_state_t;

  ctrl_state_t                ctrl_state;
  voice_state_t               voice_state [VOICE_COUNT];
  logic [AGE_WIDTH-1:0]       voice_age   [VOICE_COUNT];

  logic                       ev_on;
  logic [NOTE_WIDTH-1:0]      ev_note;
  logic [VELOCITY_WIDTH-1:0]  ev_velocity;
  logic                       tgt_valid;
  logic                       tgt_on;
  logic [IDX_WIDTH-1:0]       tgt_idx;

  logic                       hit_found, free_found, rel_found, held_found, off_found;
  logic [IDX_WIDTH-1:0]       hit_idx, free_idx, rel_idx, held_idx, off_idx;
  logic [AGE_WIDTH-1:0]       rel_age, held_age;
  logic                       sel_valid, sel_steal;
  logic [IDX_WIDTH-1:0]       sel_idx;

  // Strict '>' on age keeps the lowest index on ties.
  always_comb begin
    hit_found = 1'b0;  hit_idx  = '0;
    free_found = 1'b0; free_idx = '0;
    rel_found = 1'b0;  rel_idx  = '0; rel_age  = '0;
    held_found = 1'b0; held_idx = '0; held_age = '0;
    off_found = 1'b0;  off_idx  = '0;
    for (int k = 0; k < VOICE_COUNT; k++) begin
      if (voice_state[k] != V_FREE && voice_note[k*NOTE_WIDTH +: NOTE_WIDTH] == ev_note && !hit_found) begin
        hit_found = 1'b1;
        hit_idx   = IDX_WIDTH'(k);
      end
      if (voice_state[k] == V_FREE && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_WIDTH'(k);
      end
      if (voice_state[k] == V_RELEASING && (!rel_found || voice_age[k] > rel_age)) begin
        rel_found = 1'b1;
        rel_idx   = IDX_WIDTH'(k);
        rel_age   = voice_age[k];
      end
      if (voice_state[k] == V_HELD && (!held_found || voice_age[k] > held_age)) begin
        held_found = 1'b1;
        held_idx   = IDX_WIDTH'(k);
        held_age   = voice_age[k];
      end
      if (voice_state[k] == V_HELD && voice_note[k*NOTE_WIDTH +: NOTE_WIDTH] == ev_note && !off_found) begin
        off_found = 1'b1;
        off_idx   = IDX_WIDTH'(k);
      end
    end

    sel_valid = 1'b0;
    sel_steal = 1'b0;
    sel_idx   = '0;
    if (ev_on) begin
      sel_valid = 1'b1;
      if (hit_found) begin
        sel_idx = hit_idx;
      end else if (free_found) begin
        sel_idx = free_idx;
      end else if (rel_found) begin
        sel_idx   = rel_idx;
        sel_steal = 1'b1;
      end else begin
        sel_idx   = held_idx;
        sel_steal = 1'b1;
      end
    end else begin
      sel_valid = off_found;
      sel_idx   = off_idx;
    end
  end

  always_comb begin
    voice_active = '0;
    voice_held   = '0;
    for (int k = 0; k < VOICE_COUNT; k++) begin
      voice_active[k] = (voice_state[k] != V_FREE);
      voice_held[k]   = (voice_state[k] == V_HELD);
    end
  end

  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      ctrl_state     <= IDLE;
      event_ready    <= 1'b1;
      ev_on          <= 1'b0;
      ev_note        <= '0;
      ev_velocity    <= '0;
      tgt_valid      <= 1'b0;
      tgt_on         <= 1'b0;
      tgt_idx        <= '0;
      voice_note_on  <= '0;
      voice_note_off <= '0;
      steal          <= 1'b0;
      voice_note     <= '0;
      voice_velocity <= '0;
      for (int k = 0; k < VOICE_COUNT; k++) begin
        voice_state[k] <= V_FREE;
        voice_age[k]   <= '0;
      end
    end else begin
      voice_note_on  <= '0;
      voice_note_off <= '0;
      steal          <= 1'b0;
      for (int k = 0; k < VOICE_COUNT; k++) begin
        if (voice_state[k] == V_RELEASING && envelope_end[k]) voice_state[k] <= V_FREE;
      end
      case (ctrl_state)
        IDLE: begin
          if (event_valid && event_ready) begin
            ev_on       <= event_is_on && (event_velocity != '0);
            ev_note     <= event_note;
            ev_velocity <= event_velocity;
            event_ready <= 1'b0;
            ctrl_state  <= SEARCH;
          end
        end
        SEARCH: begin
          tgt_valid <= sel_valid;
          tgt_on    <= ev_on;
          tgt_idx   <= sel_idx;
          if (sel_valid) begin
            if (ev_on) voice_note_on  <= VOICE_COUNT'(1) << sel_idx;
            else       voice_note_off <= VOICE_COUNT'(1) << sel_idx;
            steal <= sel_steal;
          end
          ctrl_state <= ISSUE;
        end
        ISSUE: begin
          // These assignments come after the envelope_end release, so the event wins a collision.
          for (int k = 0; k < VOICE_COUNT; k++) begin
            if (tgt_valid && tgt_idx == IDX_WIDTH'(k)) begin
              if (tgt_on) begin
                voice_state[k] <= V_HELD;
                voice_age[k]   <= '0;
                voice_note[k*NOTE_WIDTH +: NOTE_WIDTH]             <= ev_note;
                voice_velocity[k*VELOCITY_WIDTH +: VELOCITY_WIDTH] <= ev_velocity;
              end else begin
                voice_state[k] <= V_RELEASING;
              end
            end else if (tgt_valid && tgt_on && voice_state[k] != V_FREE && voice_age[k] != '1) begin
              voice_age[k] <= voice_age[k] + 1'b1;
            end
          end
          event_ready <= 1'b1;
          ctrl_state  <= IDLE;
        end
        default: begin
          event_ready <= 1'b1;
          ctrl_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed bench for voice_allocator
module tb_voice_allocator;

  logic        clock_50_000_000;
  logic        reset_l;
  logic        event_valid;
  logic        event_ready;
  logic        event_is_on;
  logic [6:0]  event_note;
  logic [6:0]  event_velocity;
  logic [7:0]  envelope_end;
  logic [7:0]  voice_note_on;
  logic [7:0]  voice_note_off;
  logic [55:0] voice_note;
  logic [55:0] voice_velocity;
  logic [7:0]  voice_active;
  logic [7:0]  voice_held;
  logic        steal;

  int total = 0;
  int bad   = 0;

  logic       r0, r1, r2, r3;
  logic [7:0] p_on, p_off;
  logic       p_steal;
  logic [7:0] stray;

  voice_allocator dut (
    .clock_50_000_000 (clock_50_000_000),
    .reset_l          (reset_l),
    .event_valid      (event_valid),
    .event_ready      (event_ready),
    .event_is_on      (event_is_on),
    .event_note       (event_note),
    .event_velocity   (event_velocity),
    .envelope_end     (envelope_end),
    .voice_note_on    (voice_note_on),
    .voice_note_off   (voice_note_off),
    .voice_note       (voice_note),
    .voice_velocity   (voice_velocity),
    .voice_active     (voice_active),
    .voice_held       (voice_held),
    .steal            (steal)
  );

  initial clock_50_000_000 = 1'b0;
  always #10 clock_50_000_000 = ~clock_50_000_000;

  task automatic apply_reset();
    reset_l      = 1'b0;
    event_valid  = 1'b0;
    envelope_end = '0;
    repeat (2) @(negedge clock_50_000_000);
    reset_l = 1'b1;
    @(negedge clock_50_000_000);
  endtask

  // One event: handshake in cycle T, observations at T+1..T+3; end_mask is driven during the ISSUE cycle.
  task automatic send(input logic on, input logic [6:0] note, input logic [6:0] vel, input logic [7:0] end_mask);
    @(negedge clock_50_000_000);
    event_valid    = 1'b1;
    event_is_on    = on;
    event_note     = note;
    event_velocity = vel;
    r0 = event_ready;
    @(posedge clock_50_000_000);
    #1 event_valid = 1'b0;
    @(negedge clock_50_000_000);
    r1 = event_ready;
    stray = voice_note_on | voice_note_off;
    @(negedge clock_50_000_000);
    r2 = event_ready;
    p_on = voice_note_on;
    p_off = voice_note_off;
    p_steal = steal;
    envelope_end = end_mask;
    @(negedge clock_50_000_000);
    envelope_end = '0;
    r3 = event_ready;
    stray = stray | voice_note_on | voice_note_off;
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (event_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", event_ready); end
    total++; if (voice_note_on !== 8'h00 || voice_note_off !== 8'h00) begin bad++; $display("FAIL reset_pulses got=%h/%h want=00/00", voice_note_on, voice_note_off); end
    total++; if (voice_active !== 8'h00 || voice_held !== 8'h00) begin bad++; $display("FAIL reset_active got=%h/%h want=00/00", voice_active, voice_held); end
    total++; if (voice_note !== 56'h0 || voice_velocity !== 56'h0 || steal !== 1'b0) begin bad++; $display("FAIL reset_regs got=%h/%h/%b want=0", voice_note, voice_velocity, steal); end
  endtask

  task automatic test_basic_note_on();
    apply_reset();
    send(1'b1, 7'd60, 7'd100, 8'h00);
    total++; if ({r0, r1, r2, r3} !== 4'b1001) begin bad++; $display("FAIL basic_ready got=%b want=1001", {r0, r1, r2, r3}); end
    total++; if (p_on !== 8'h01 || p_off !== 8'h00) begin bad++; $display("FAIL basic_pulse got=%h/%h want=01/00", p_on, p_off); end
    total++; if (p_steal !== 1'b0) begin bad++; $display("FAIL basic_steal got=%b want=0", p_steal); end
    total++; if (stray !== 8'h00) begin bad++; $display("FAIL basic_stray got=%h want=00", stray); end
    total++; if (voice_note[6:0] !== 7'd60 || voice_velocity[6:0] !== 7'd100) begin bad++; $display("FAIL basic_regs got=%0d/%0d want=60/100", voice_note[6:0], voice_velocity[6:0]); end
    total++; if (voice_held !== 8'h01 || voice_active !== 8'h01) begin bad++; $display("FAIL basic_held got=%h/%h want=01/01", voice_held, voice_active); end
  endtask

  task automatic test_release();
    send(1'b0, 7'd60, 7'd0, 8'h00);
    total++; if (p_off !== 8'h01 || p_on !== 8'h00 || stray !== 8'h00) begin bad++; $display("FAIL release_pulse got=%h/%h/%h want=01/00/00", p_off, p_on, stray); end
    total++; if (voice_held !== 8'h00 || voice_active !== 8'h01) begin bad++; $display("FAIL release_state got=%h/%h want=00/01", voice_held, voice_active); end
    send(1'b0, 7'd61, 7'd0, 8'h00);
    total++; if (p_off !== 8'h00 || p_on !== 8'h00 || stray !== 8'h00) begin bad++; $display("FAIL release_nomatch got=%h/%h want=00/00", p_off, p_on); end
    envelope_end = 8'h01;
    @(negedge clock_50_000_000);
    envelope_end = 8'h00;
    total++; if (voice_active !== 8'h00) begin bad++; $display("FAIL release_free got=%h want=00", voice_active); end
    total++; if (voice_note[6:0] !== 7'd60) begin bad++; $display("FAIL release_note_kept got=%0d want=60", voice_note[6:0]); end
  endtask

  task automatic test_steal_releasing();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 7'(60 + i), 7'd80, 8'h00);
      total++; if (p_on !== (8'h01 << i)) begin bad++; $display("FAIL fill_%0d got=%h want=%h", i, p_on, 8'h01 << i); end
    end
    send(1'b0, 7'd60, 7'd0, 8'h00);
    send(1'b1, 7'd70, 7'd90, 8'h00);
    total++; if (p_on !== 8'h01 || p_off !== 8'h00 || p_steal !== 1'b1) begin bad++; $display("FAIL steal_rel got=%h/%h/%b want=01/00/1", p_on, p_off, p_steal); end
    total++; if (voice_note[6:0] !== 7'd70 || voice_held !== 8'hFF) begin bad++; $display("FAIL steal_rel_state got=%0d/%h want=70/ff", voice_note[6:0], voice_held); end
  endtask

  task automatic test_steal_held();
    apply_reset();
    for (int i = 0; i < 8; i++) send(1'b1, 7'(60 + i), 7'd80, 8'h00);
    send(1'b1, 7'd70, 7'd90, 8'h00);
    total++; if (p_on !== 8'h01 || p_off !== 8'h00 || p_steal !== 1'b1) begin bad++; $display("FAIL steal_held got=%h/%h/%b want=01/00/1", p_on, p_off, p_steal); end
    total++; if (voice_note[6:0] !== 7'd70) begin bad++; $display("FAIL steal_held_note got=%0d want=70", voice_note[6:0]); end
    send(1'b1, 7'd71, 7'd90, 8'h00);
    total++; if (p_on !== 8'h02 || p_steal !== 1'b1) begin bad++; $display("FAIL steal_next_oldest got=%h/%b want=02/1", p_on, p_steal); end
    total++; if (voice_note[13:7] !== 7'd71) begin bad++; $display("FAIL steal_next_note got=%0d want=71", voice_note[13:7]); end
  endtask

  task automatic test_velocity_zero_and_retrigger();
    apply_reset();
    send(1'b1, 7'd62, 7'd50, 8'h00);
    send(1'b1, 7'd63, 7'd50, 8'h00);
    send(1'b1, 7'd64, 7'd50, 8'h00);
    send(1'b1, 7'd64, 7'd0, 8'h00);
    total++; if (p_off !== 8'h04 || p_on !== 8'h00) begin bad++; $display("FAIL vel0_off got=%h/%h want=04/00", p_off, p_on); end
    send(1'b1, 7'd64, 7'd90, 8'h00);
    total++; if (p_on !== 8'h04 || p_steal !== 1'b0) begin bad++; $display("FAIL retrigger got=%h/%b want=04/0", p_on, p_steal); end
    total++; if (voice_velocity[20:14] !== 7'd90 || voice_held !== 8'h07) begin bad++; $display("FAIL retrigger_state got=%0d/%h want=90/07", voice_velocity[20:14], voice_held); end
  endtask

  task automatic test_end_collision();
    apply_reset();
    for (int i = 0; i < 4; i++) send(1'b1, 7'(10 + i), 7'd40, 8'h00);
    send(1'b0, 7'd13, 7'd0, 8'h00);
    total++; if (p_off !== 8'h08) begin bad++; $display("FAIL collide_off got=%h want=08", p_off); end
    send(1'b1, 7'd13, 7'd40, 8'h08);
    total++; if (p_on !== 8'h08 || p_steal !== 1'b0) begin bad++; $display("FAIL collide_on got=%h/%b want=08/0", p_on, p_steal); end
    total++; if (voice_held[3] !== 1'b1 || voice_active[3] !== 1'b1) begin bad++; $display("FAIL collide_held got=%b/%b want=1/1", voice_held[3], voice_active[3]); end
  endtask

  task automatic test_reset_mid_search();
    apply_reset();
    send(1'b1, 7'd30, 7'd60, 8'h00);
    @(negedge clock_50_000_000);
    event_valid    = 1'b1;
    event_is_on    = 1'b1;
    event_note     = 7'd20;
    event_velocity = 7'd70;
    @(posedge clock_50_000_000);
    #1 event_valid = 1'b0;
    @(negedge clock_50_000_000);
    reset_l = 1'b0;
    #2;
    total++; if (event_ready !== 1'b1 || steal !== 1'b0) begin bad++; $display("FAIL midreset_ready got=%b/%b want=1/0", event_ready, steal); end
    total++; if (voice_active !== 8'h00 || voice_note !== 56'h0 || voice_velocity !== 56'h0) begin bad++; $display("FAIL midreset_clear got=%h/%h want=00/0", voice_active, voice_note); end
    @(negedge clock_50_000_000);
    reset_l = 1'b1;
    stray = '0;
    repeat (4) begin
      @(negedge clock_50_000_000);
      stray = stray | voice_note_on | voice_note_off;
    end
    total++; if (stray !== 8'h00 || event_ready !== 1'b1) begin bad++; $display("FAIL midreset_nopulse got=%h/%b want=00/1", stray, event_ready); end
    send(1'b1, 7'd20, 7'd70, 8'h00);
    total++; if (p_on !== 8'h01 || voice_note[6:0] !== 7'd20) begin bad++; $display("FAIL midreset_after got=%h/%0d want=01/20", p_on, voice_note[6:0]); end
  endtask

  initial begin
    reset_l        = 1'b0;
    event_valid    = 1'b0;
    event_is_on    = 1'b0;
    event_note     = '0;
    event_velocity = '0;
    envelope_end   = '0;
    test_reset();
    test_basic_note_on();
    test_release();
    test_steal_releasing();
    test_steal_held();
    test_velocity_zero_and_retrigger();
    test_end_collision();
    test_reset_mid_search();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Polyphonic voice scheduler between the MIDI event decoder and the bank of per-voice Envelope/oscillator pipelines.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of VOICE_COUNT voices.
- Issues one-cycle note_on/note_off pulses to the chosen voice's envelope, and frees voices when their envelope_end is reported.
- When every voice is busy, steals the oldest voice.

Parameters:
VOICE_COUNT, 8, number of voice pipelines.
NOTE_WIDTH, 7, MIDI note number width.
VELOCITY_WIDTH, 7, MIDI velocity width.
AGE_WIDTH, 8, saturating per-voice age counter width.

Ports:
clock_50_000_000  input  1  system clock; all logic on its rising edge.
reset_l  input  1  asynchronous, active-low reset.
event_valid  input  1  event present.
event_ready  output  1  allocator can accept an event.
event_is_on  input  1  1 = note-on, 0 = note-off.
event_note  input  NOTE_WIDTH  note number.
event_velocity  input  VELOCITY_WIDTH  velocity; ignored for note-off.
envelope_end  input  VOICE_COUNT  per-voice one-cycle pulse: release finished.
voice_note_on  output  VOICE_COUNT  one-cycle trigger to that voice's envelope.
voice_note_off  output  VOICE_COUNT  one-cycle release to that voice's envelope.
voice_note  output  VOICE_COUNT*NOTE_WIDTH  registered note per voice; voice k occupies bits [k*NOTE_WIDTH +: NOTE_WIDTH].
voice_velocity  output  VOICE_COUNT*VELOCITY_WIDTH  registered velocity per voice.
voice_active  output  VOICE_COUNT  voice is HELD or RELEASING.
voice_held  output  VOICE_COUNT  voice is HELD (gate down).
steal  output  1  one-cycle pulse, coincident with note_on, when an active voice was reassigned.

Behaviour:
- Reset value of every output is 0, except event_ready, which is 1. Reset sets every voice state to FREE and every age to 0.
- Reset asserted mid-operation aborts any in-flight event; no pulse is emitted for it.
- Per-voice states:
  - FREE -> HELD on an assigned note-on.
  - HELD -> RELEASING on a matched note-off.
  - RELEASING -> FREE on envelope_end[k].
  - RELEASING or HELD -> HELD on a retrigger or steal.
- envelope_end[k] is ignored when voice k is not RELEASING.
- Control FSM states are IDLE, SEARCH and ISSUE.
  - IDLE: event_ready = 1. The handshake completes when event_valid && event_ready; the event is latched and the FSM goes to SEARCH.
  - SEARCH: event_ready = 0. The target voice is computed and registered; the FSM goes to ISSUE.
  - ISSUE: event_ready = 0. Pulses and per-voice registers update in this cycle; the FSM returns to IDLE.
  - Latency: handshake in cycle T, pulse in cycle T+2. Throughput is one event per 3 cycles.
- A note-on with velocity 0 is treated as a note-off.
- Note-on target selection, first match wins:
  1. A HELD or RELEASING voice already carrying event_note (retrigger; steal = 0).
  2. The lowest-index FREE voice.
  3. The RELEASING voice with the largest age (steal = 1).
  4. The HELD voice with the largest age (steal = 1).
  - Age ties resolve to the lowest index.
  - On the target: voice_note_on[k] pulses, note and velocity are loaded, state becomes HELD and age is cleared to 0.
  - On every other active voice: age increments, saturating at 2^AGE_WIDTH-1.
  - No note_off is emitted for a stolen voice; the envelope restarts attack on note_on.
- Note-off: the target is the lowest-index HELD voice whose note equals event_note. On that voice, voice_note_off[k] pulses and the state becomes RELEASING. If no voice matches, the event is consumed silently with no pulse.
- envelope_end[k] in the same cycle as ISSUE targeting voice k: the ISSUE result wins; the voice ends HELD or RELEASING per the event, never FREE.
- envelope_end is processed in every FSM state, including SEARCH. SEARCH uses the state registered at the start of that cycle.
- At most one bit of voice_note_on | voice_note_off is set in any cycle.
- voice_note and voice_velocity hold their last values after the voice is freed.

Test Plan:
- Reset, then note-on 60 vel 100 at cycle T -> voice_note_on = 8'b0000_0001 at T+2; voice_note[6:0] = 60; voice_held[0] = 1; event_ready low at T+1 and T+2, high at T+3.
- Note-on 60, note-off 60, envelope_end[0] pulse -> voice_note_off[0] pulses once at 2 cycles after the note-off handshake; voice_active[0] = 0 the cycle after envelope_end; a note-off for 61 yields no pulse.
- Eight note-ons 60..67, then note-off 60, then note-on 70 -> note 70 goes to voice 0 (the RELEASING voice), steal = 1, no note_off emitted.
- Eight held notes 60..67, then note-on 70 -> voice 0 (largest age) is stolen; voice_note[6:0] = 70; steal = 1.
- Note-on 64 vel 0 while 64 is held on voice 2 -> voice_note_off[2] pulses. A repeated note-on 64 vel 90 -> voice_note_on[2] retrigger, steal = 0.
- envelope_end[3] in the ISSUE cycle of a note-on targeting voice 3 -> voice 3 ends HELD; reset_l low mid-SEARCH -> no pulses, all outputs 0, event_ready = 1.
